mealy_seq_detector: RTL and testbench
=====================================

// Module: mealy_seq_detector
// PURPOSE
//  Parametrised Mealy serial-pattern detector; generalises the fixed 4-state Mealy FSM.
//  Compares a 1-bit qualified input stream against a runtime-loadable N-bit pattern.
//  Supports overlapping and non-overlapping match modes and keeps a saturating match count.
//  Sits on serial front-end links; feeds frame-sync and event-count logic.
// PARAMETERS
//  PAT_LEN    4        pattern length in bits, N >= 2
//  CNT_W      8        match counter width
//  RST_PAT    4'b1011  pattern used out of reset, PAT_LEN bits
//  RST_OVL    1'b1     overlap mode out of reset: 1 = overlap, 0 = non-overlap
// PORTS
//  clck         in   1        single clock, rising edge
//  rst          in   1        synchronous reset, active-high
//  cfg_load     in   1        load cfg_pattern/cfg_overlap this cycle
//  cfg_pattern  in   PAT_LEN  new pattern; bit [N-1] is the earliest bit received
//  cfg_overlap  in   1        new overlap mode
//  in_valid     in   1        inp is valid this cycle
//  inp          in   1        serial data bit
//  out          out  1        Mealy match pulse, combinational from state, inp, in_valid
//  match_cnt    out  CNT_W    registered matches, saturates at all-ones
//  armed        out  1        history holds >= N-1 valid bits
// BEHAVIOUR
//  - Clock and reset: one clock, clck; synchronous active-high reset, rst.
//  - Reset values: hist=0, fill=0, pat=RST_PAT, ovl=RST_OVL, match_cnt=0, armed=0.
//    out=0 while rst is high.
//  - State: hist[N-2:0] holds the last N-1 accepted bits, newest in the LSB.
//    fill counts valid history bits, 0..N-1, and saturates at N-1.
//  - FSM, state encoding in the package:
//    FILL: fill < N-1.
//    ARMED: fill == N-1.
//    FILL -> ARMED when the accepted bit brings fill to N-1.
//    ARMED -> FILL on a match when ovl=0, on cfg_load, or on rst.
//  - Mealy output, same cycle, no latency:
//    out = in_valid & ~cfg_load & ARMED & ({hist,inp} == pat).
//  - Accepting a bit: when in_valid=1 and cfg_load=0, hist <= {hist[N-3:0],inp}.
//    fill increments, saturating.
//  - On a match:
//    ovl=1: keep the shifted hist; the next match can reuse bits.
//    ovl=0: hist<=0 and fill<=0; the next match needs N fresh bits.
//  - match_cnt increments on the clock edge that ends a cycle with out=1.
//    When match_cnt is all-ones it holds.
//  - in_valid=0: no state change and out=0; gaps of any length are transparent.
//  - cfg_load=1, with or without in_valid: load wins.
//    pat and ovl take the cfg_* values; hist and fill clear; the input bit is dropped; out=0.
//    match_cnt is kept.
//  - rst=1 has priority over every other input and aborts a partial match.
//  - armed is the registered ARMED flag.
// STRUCTURE
//  - Package mealy_pkg: FSM state localparams (ST_FILL, ST_ARMED) and the fill-width function.
//  - Sub-module sat_counter, params W and the increment enable, implements match_cnt.
//  - Everything else is inline: history shift register, fill counter, compare, FSM.
// TESTING
//  1. Reset with defaults (pattern 1011, overlap=1), drive 1,0,1,1,0,1,1 every cycle.
//     out=1 on the 4th and 7th bits only; match_cnt=2.
//  2. Load pattern 1010 with overlap=0, stream 1,0,1,0,1,0.
//     out=1 on the 4th bit only; match_cnt=1.
//     With overlap=1 the same stream gives out on the 4th and 6th bits; match_cnt=2.
//  3. Default pattern, stream 1,0,1,1 with in_valid=0 gaps of 0, 1 and 3 cycles between bits.
//     One out pulse, only on the cycle carrying the final valid 1; out=0 in the gap cycles.
//  4. After 1,0,1 (armed=1), assert cfg_load together with in_valid=1 and inp=1.
//     out=0; armed=0; 1011 then matches only after 4 more valid bits.
//  5. CNT_W=2, overlap=1, pattern 11, stream of 6 ones.
//     out pulses on bits 2 through 6; match_cnt goes 1, 2, 3 and holds at 3.
//  6. Assert rst after 1,0,1, then release and send 1.
//     No match and armed=0; match_cnt=0; full 1011 is needed afterwards.

Source files
------------

// File: rtl/mealy_pkg.sv
// Shared definitions for the Mealy serial-pattern detector.
//   state_t    : detector FSM state (history still filling / history armed)
//   fill_width : width of the counter that tracks valid history bits (0..pat_len-1)
package mealy_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // The counter must reach pat_len-1. At least one bit is always needed.
    function automatic int unsigned fill_width(input int unsigned pat_len);
        return (pat_len <= 2) ? 1 : $clog2(pat_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on reset, increments on en, holds at all-ones.
// Ports:
//   clck  in   1  clock, rising edge
//   rst   in   1  synchronous reset, active-high
//   en    in   1  increment request
//   cnt   out  W  current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clck,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clck) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial-pattern detector with a runtime-loadable PAT_LEN-bit pattern,
// overlapping / non-overlapping match modes and a saturating match counter.
// Ports:
//   clck         in   1        clock, rising edge
//   rst          in   1        synchronous reset, active-high
//   cfg_load     in   1        load cfg_pattern / cfg_overlap; clears history
//   cfg_pattern  in   PAT_LEN  new pattern, bit [PAT_LEN-1] is the earliest bit
//   cfg_overlap  in   1        new mode: 1 = overlap, 0 = non-overlap
//   in_valid     in   1        inp is valid this cycle
//   inp          in   1        serial data bit
//   out          out  1        same-cycle match pulse
//   match_cnt    out  CNT_W    registered match count, saturating
//   armed        out  1        history holds PAT_LEN-1 valid bits
module mealy_seq_detector
    import mealy_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 4,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [PAT_LEN-1:0]   RST_PAT = 4'b1011,
    parameter logic                 RST_OVL = 1'b1
) (
    input  logic               clck,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               inp,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int unsigned         FILL_W   = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_LEN - 1);

    state_t               state_q, state_d;
    logic [PAT_LEN-2:0]   hist_q,  hist_d;
    logic [FILL_W-1:0]    fill_q,  fill_d;
    logic [PAT_LEN-1:0]   pat_q,   pat_d;
    logic                 ovl_q,   ovl_d;

    logic [PAT_LEN-1:0]   cand;
    logic [FILL_W-1:0]    fill_inc;
    logic                 hit;

    // State register
    always_ff @(posedge clck) begin
        if (rst) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RST_PAT;
            ovl_q   <= RST_OVL;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    // Next-state and Mealy output
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;

        // Candidate window: stored history plus the bit arriving now. Its low
        // PAT_LEN-1 bits are also the shifted history, which avoids a
        // hist[PAT_LEN-3:0] slice that would be empty for PAT_LEN=2.
        cand     = {hist_q, inp};
        fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

        hit = in_valid && !cfg_load && (state_q == ST_ARMED) && (cand == pat_q);
        out = hit && !rst;

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (in_valid) begin
            if (hit && !ovl_q) begin
                // Non-overlap: the next match has to be built from fresh bits.
                hist_d  = '0;
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                hist_d  = cand[PAT_LEN-2:0];
                fill_d  = fill_inc;
                state_d = (fill_inc == FILL_MAX) ? ST_ARMED : ST_FILL;
            end
        end
    end

    assign armed = (state_q == ST_ARMED);

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clck (clck),
        .rst  (rst),
        .en   (out),
        .cnt  (match_cnt)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
module tb_mealy_seq_detector;

    logic       clk;
    logic       rst;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       in_valid;
    logic       inp;
    logic       out;
    logic [7:0] match_cnt;
    logic       armed;

    // Second instance: 2-bit pattern, 2-bit counter, for saturation
    logic       rst2;
    logic       cfg_load2;
    logic [1:0] cfg_pattern2;
    logic       cfg_overlap2;
    logic       in_valid2;
    logic       inp2;
    logic       out2;
    logic [1:0] match_cnt2;
    logic       armed2;

    int tests;
    int fails;

    mealy_seq_detector #(
        .PAT_LEN (4),
        .CNT_W   (8),
        .RST_PAT (4'b1011),
        .RST_OVL (1'b1)
    ) dut (
        .clck        (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .inp         (inp),
        .out         (out),
        .match_cnt   (match_cnt),
        .armed       (armed)
    );

    mealy_seq_detector #(
        .PAT_LEN (2),
        .CNT_W   (2),
        .RST_PAT (2'b11),
        .RST_OVL (1'b1)
    ) dut2 (
        .clck        (clk),
        .rst         (rst2),
        .cfg_load    (cfg_load2),
        .cfg_pattern (cfg_pattern2),
        .cfg_overlap (cfg_overlap2),
        .in_valid    (in_valid2),
        .inp         (inp2),
        .out         (out2),
        .match_cnt   (match_cnt2),
        .armed       (armed2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply inputs mid-cycle, leaving time for out to settle before sampling
    task automatic drive(input logic v, input logic b);
        cfg_load = 1'b0;
        in_valid = v;
        inp      = b;
        #2;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        inp      = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_cfg(input logic [3:0] p, input logic o);
        rst         = 1'b0;
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_overlap = o;
        in_valid    = 1'b0;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b1;
        inp      = 1'b1;
        cfg_load = 1'b0;
        tick();
        tick();
        #2;
        tests++;
        if (out !== 1'b0) begin
            fails++; $display("FAIL reset_out: got %b want 0", out);
        end
        tests++;
        if (armed !== 1'b0) begin
            fails++; $display("FAIL reset_armed: got %b want 0", armed);
        end
        tests++;
        if (match_cnt !== 8'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_overlap_default;
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_o = 7'b0001001;
        logic [6:0] exp_a = 7'b0011111;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            tests++;
            if (out !== exp_o[i]) begin
                fails++; $display("FAIL ovl_default_out bit%0d: got %b want %b", 7 - i, out, exp_o[i]);
            end
            tick();
            tests++;
            if (armed !== exp_a[i]) begin
                fails++; $display("FAIL ovl_default_armed bit%0d: got %b want %b", 7 - i, armed, exp_a[i]);
            end
        end
        tests++;
        if (match_cnt !== 8'd2) begin
            fails++; $display("FAIL ovl_default_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_nonoverlap;
        logic [5:0] bits   = 6'b101010;
        logic [5:0] exp_no = 6'b000100;
        logic [5:0] exp_ov = 6'b000101;
        do_reset();
        load_cfg(4'b1010, 1'b0);
        for (int i = 5; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            tests++;
            if (out !== exp_no[i]) begin
                fails++; $display("FAIL nonovl_out bit%0d: got %b want %b", 6 - i, out, exp_no[i]);
            end
            tick();
            if (i == 2) begin
                tests++;
                if (armed !== 1'b0) begin
                    fails++; $display("FAIL nonovl_armed_after_match: got %b want 0", armed);
                end
            end
        end
        tests++;
        if (match_cnt !== 8'd1) begin
            fails++; $display("FAIL nonovl_cnt: got %0d want 1", match_cnt);
        end

        do_reset();
        load_cfg(4'b1010, 1'b1);
        for (int i = 5; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            tests++;
            if (out !== exp_ov[i]) begin
                fails++; $display("FAIL ovl1010_out bit%0d: got %b want %b", 6 - i, out, exp_ov[i]);
            end
            tick();
        end
        tests++;
        if (match_cnt !== 8'd2) begin
            fails++; $display("FAIL ovl1010_cnt: got %0d want 2", match_cnt);
        end
    endtask

    task automatic test_gaps;
        // bit1, bit2, gap, bit3, gap x3, bit4; gap cycles carry inp=1
        logic [7:0] v_vec = 8'b11010001;
        logic [7:0] i_vec = 8'b10111111;
        logic [7:0] e_vec = 8'b00000001;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            drive(v_vec[i], i_vec[i]);
            tests++;
            if (out !== e_vec[i]) begin
                fails++; $display("FAIL gaps_out cyc%0d: got %b want %b", 8 - i, out, e_vec[i]);
            end
            tick();
        end
        tests++;
        if (match_cnt !== 8'd1) begin
            fails++; $display("FAIL gaps_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_load_abort;
        logic [3:0] bits  = 4'b1011;
        logic [3:0] exp_o = 4'b0001;
        do_reset();
        drive(1'b1, 1'b1); tick();
        drive(1'b1, 1'b0); tick();
        drive(1'b1, 1'b1); tick();
        tests++;
        if (armed !== 1'b1) begin
            fails++; $display("FAIL load_pre_armed: got %b want 1", armed);
        end
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1011;
        cfg_overlap = 1'b1;
        in_valid    = 1'b1;
        inp         = 1'b1;
        #2;
        tests++;
        if (out !== 1'b0) begin
            fails++; $display("FAIL load_out: got %b want 0", out);
        end
        tick();
        cfg_load = 1'b0;
        tests++;
        if (armed !== 1'b0) begin
            fails++; $display("FAIL load_armed: got %b want 0", armed);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            tests++;
            if (out !== exp_o[i]) begin
                fails++; $display("FAIL load_after_out bit%0d: got %b want %b", 4 - i, out, exp_o[i]);
            end
            tick();
        end
        tests++;
        if (match_cnt !== 8'd1) begin
            fails++; $display("FAIL load_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_saturate;
        logic [5:0] exp_o = 6'b011111;
        logic [1:0] exp_c [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst2 = 1'b1; in_valid2 = 1'b0; inp2 = 1'b0;
        tick();
        rst2 = 1'b0;
        tests++;
        if (match_cnt2 !== 2'd0) begin
            fails++; $display("FAIL sat_reset_cnt: got %0d want 0", match_cnt2);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid2 = 1'b1;
            inp2      = 1'b1;
            #2;
            tests++;
            if (out2 !== exp_o[5 - i]) begin
                fails++; $display("FAIL sat_out bit%0d: got %b want %b", i + 1, out2, exp_o[5 - i]);
            end
            tick();
            tests++;
            if (match_cnt2 !== exp_c[i]) begin
                fails++; $display("FAIL sat_cnt bit%0d: got %0d want %0d", i + 1, match_cnt2, exp_c[i]);
            end
        end
        in_valid2 = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [3:0] bits  = 4'b1011;
        logic [3:0] exp_o = 4'b0001;
        do_reset();
        drive(1'b1, 1'b1); tick();
        drive(1'b1, 1'b0); tick();
        drive(1'b1, 1'b1); tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        inp      = 1'b1;
        #2;
        tests++;
        if (out !== 1'b0) begin
            fails++; $display("FAIL rst_abort_out_in_rst: got %b want 0", out);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1);
        tests++;
        if (out !== 1'b0) begin
            fails++; $display("FAIL rst_abort_out_after: got %b want 0", out);
        end
        tick();
        tests++;
        if (armed !== 1'b0) begin
            fails++; $display("FAIL rst_abort_armed: got %b want 0", armed);
        end
        tests++;
        if (match_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_abort_cnt: got %0d want 0", match_cnt);
        end
        // The bit sent after reset counts as the first of a fresh 1011
        for (int i = 2; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            tests++;
            if (out !== exp_o[i]) begin
                fails++; $display("FAIL rst_abort_refill bit%0d: got %b want %b", 4 - i, out, exp_o[i]);
            end
            tick();
        end
        tests++;
        if (match_cnt !== 8'd1) begin
            fails++; $display("FAIL rst_abort_final_cnt: got %0d want 1", match_cnt);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        cfg_load     = 1'b0;
        cfg_pattern  = 4'b0000;
        cfg_overlap  = 1'b0;
        in_valid     = 1'b0;
        inp          = 1'b0;
        rst2         = 1'b1;
        cfg_load2    = 1'b0;
        cfg_pattern2 = 2'b00;
        cfg_overlap2 = 1'b0;
        in_valid2    = 1'b0;
        inp2         = 1'b0;
        tick();

        test_reset();
        test_overlap_default();
        test_nonoverlap();
        test_gaps();
        test_load_abort();
        test_saturate();
        test_reset_abort();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
